// File: rtl/fexp2_top.sv
// rtl/fexp2_top.sv - iterative bfloat16 base-2 antilogarithm, y = 2^x
module fexp2_top #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 7,
    parameter int BIAS      = 127,
    parameter int FRAC_W    = 16,
    parameter int INT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sign,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [MAN_WIDTH-1:0] fractional,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 s_res_o,
    output logic [EXP_WIDTH-1:0] e_res_o,
    output logic [MAN_WIDTH-1:0] f_res_o,
    output logic                 valid_o
);

    localparam int FIX_W = INT_W + FRAC_W;
    localparam int ACC_W = FRAC_W + 1;
    localparam int K_W   = $clog2(FRAC_W + 1);
    localparam int ER_W  = EXP_WIDTH + 2;

    localparam logic signed [ER_W-1:0] BIAS_S  = ER_W'(BIAS);
    localparam logic signed [ER_W-1:0] E_MAX   = ER_W'(INT_W - 1);
    localparam logic signed [ER_W-1:0] SH_OFS  = ER_W'(FRAC_W - MAN_WIDTH);
    localparam logic signed [ER_W-1:0] ER_TOP  = ER_W'((1 << EXP_WIDTH) - 1);
    localparam logic [K_W-1:0]         K_LAST  = K_W'(FRAC_W);
    localparam logic [ACC_W-1:0]       ACC_ONE = ACC_W'(1) << FRAC_W;
    localparam logic [EXP_WIDTH-1:0]   EXP_ONES = '1;
    localparam logic [EXP_WIDTH-1:0]   EXP_BIAS = EXP_WIDTH'(BIAS);
    localparam logic [MAN_WIDTH-1:0]   MAN_QNAN = MAN_WIDTH'(1) << (MAN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        ITER,
        PACK
    } state_t;

    typedef enum logic [2:0] {
        SP_NONE,
        SP_ONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } special_t;

    state_t   state, state_nxt;
    special_t spec_q, spec_c;

    logic                 op_sign;
    logic [EXP_WIDTH-1:0] op_exp;
    logic [MAN_WIDTH-1:0] op_man;

    logic [INT_W-1:0]  int_q;
    logic [FRAC_W-1:0] frac_sh;
    logic [ACC_W-1:0]  acc;
    logic [K_W-1:0]    k;

    logic signed [ER_W-1:0] e_unb;
    logic signed [ER_W-1:0] sh;
    logic [ER_W-1:0]        sh_mag;
    logic [FIX_W-1:0]       mant_ext;
    logic [FIX_W-1:0]       mag;
    logic [FIX_W-1:0]       fixed;

    logic [2*ACC_W-1:0] prod;
    logic [ACC_W-1:0]   acc_mul;
    logic signed [ER_W-1:0] er;

    // 2^(2^-k) in Q1.16, rounded to nearest; table built offline for FRAC_W=16
    function automatic logic [ACC_W-1:0] rom_c(input logic [K_W-1:0] idx);
        logic [ACC_W-1:0] c;
        case (int'(idx))
            1:       c = ACC_W'(92682);
            2:       c = ACC_W'(77936);
            3:       c = ACC_W'(71468);
            4:       c = ACC_W'(68438);
            5:       c = ACC_W'(66971);
            6:       c = ACC_W'(66250);
            7:       c = ACC_W'(65892);
            8:       c = ACC_W'(65714);
            9:       c = ACC_W'(65625);
            10:      c = ACC_W'(65580);
            11:      c = ACC_W'(65558);
            12:      c = ACC_W'(65547);
            13:      c = ACC_W'(65542);
            14:      c = ACC_W'(65539);
            15:      c = ACC_W'(65537);
            16:      c = ACC_W'(65537);
            default: c = ACC_ONE;
        endcase
        return c;
    endfunction

    assign ready_o = (state == IDLE);

    // Operand decode: float -> signed Q(INT_W).FRAC_W plus special-class flag
    always_comb begin
        e_unb    = $signed({2'b00, op_exp}) - BIAS_S;
        sh       = e_unb + SH_OFS;
        sh_mag   = '0;
        mant_ext = FIX_W'({1'b1, op_man});
        mag      = '0;
        spec_c   = SP_NONE;
        if (sh[ER_W-1]) begin
            sh_mag = -sh;
            mag    = mant_ext >> sh_mag;
        end else begin
            sh_mag = sh;
            mag    = mant_ext << sh_mag;
        end
        fixed = op_sign ? -mag : mag;

        if (op_exp == '0) begin
            spec_c = SP_ONE;
        end else if (op_exp == EXP_ONES) begin
            if (op_man != '0) begin
                spec_c = SP_NAN;
            end else begin
                spec_c = op_sign ? SP_ZERO : SP_INF;
            end
        end else if (e_unb >= E_MAX) begin
            spec_c = op_sign ? SP_ZERO : SP_INF;
        end
    end

    // One conditional multiply step per cycle and the packed exponent
    always_comb begin
        prod    = {{ACC_W{1'b0}}, acc} * {{ACC_W{1'b0}}, rom_c(k)};
        acc_mul = ACC_W'(prod >> FRAC_W);
        er      = $signed({{(ER_W-INT_W){int_q[INT_W-1]}}, int_q}) + BIAS_S;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE -> ALIGN -> ITER (FRAC_W cycles) -> PACK -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i) state_nxt = ALIGN;
            ALIGN:   state_nxt = ITER;
            ITER:    if (k == K_LAST) state_nxt = PACK;
            PACK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_sign <= 1'b0;
            op_exp  <= '0;
            op_man  <= '0;
            int_q   <= '0;
            frac_sh <= '0;
            spec_q  <= SP_NONE;
            acc     <= '0;
            k       <= '0;
            s_res_o <= 1'b0;
            e_res_o <= '0;
            f_res_o <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        op_sign <= sign;
                        op_exp  <= exponent;
                        op_man  <= fractional;
                    end
                end
                ALIGN: begin
                    int_q   <= fixed[FIX_W-1:FRAC_W];
                    frac_sh <= fixed[FRAC_W-1:0];
                    spec_q  <= spec_c;
                    acc     <= ACC_ONE;
                    k       <= K_W'(1);
                end
                ITER: begin
                    // fraction bits are consumed MSB first, matching C_1, C_2, ...
                    if (frac_sh[FRAC_W-1]) begin
                        acc <= acc_mul;
                    end
                    frac_sh <= frac_sh << 1;
                    k       <= k + K_W'(1);
                end
                PACK: begin
                    s_res_o <= 1'b0;
                    valid_o <= 1'b1;
                    case (spec_q)
                        SP_ONE: begin
                            e_res_o <= EXP_BIAS;
                            f_res_o <= '0;
                        end
                        SP_NAN: begin
                            e_res_o <= EXP_ONES;
                            f_res_o <= MAN_QNAN;
                        end
                        SP_INF: begin
                            e_res_o <= EXP_ONES;
                            f_res_o <= '0;
                        end
                        SP_ZERO: begin
                            e_res_o <= '0;
                            f_res_o <= '0;
                        end
                        default: begin
                            if (er <= 0) begin
                                e_res_o <= '0;
                                f_res_o <= '0;
                            end else if (er >= ER_TOP) begin
                                e_res_o <= EXP_ONES;
                                f_res_o <= '0;
                            end else begin
                                e_res_o <= er[EXP_WIDTH-1:0];
                                f_res_o <= acc[FRAC_W-1 -: MAN_WIDTH];
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fexp2_top.sv
// tb/tb_fexp2_top.sv - directed-vector bench for fexp2_top
module tb_fexp2_top;

    logic       clk;
    logic       rst_n;
    logic       sign;
    logic [7:0] exponent;
    logic [6:0] fractional;
    logic       valid_i;
    logic       ready_o;
    logic       s_res_o;
    logic [7:0] e_res_o;
    logic [6:0] f_res_o;
    logic       valid_o;

    int tests;
    int fails;
    int pulses;

    fexp2_top dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sign       (sign),
        .exponent   (exponent),
        .fractional (fractional),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .s_res_o    (s_res_o),
        .e_res_o    (e_res_o),
        .f_res_o    (f_res_o),
        .valid_o    (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count result strobes, sampled mid-cycle
    always @(negedge clk) begin
        if (valid_o === 1'b1) pulses++;
    end

    function automatic logic [15:0] result();
        return {s_res_o, e_res_o, f_res_o};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] x);
        sign       = x[15];
        exponent   = x[14:7];
        fractional = x[6:0];
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_rdy"}, ready_o, 1);
    endtask

    // counts edges after the accepting edge until valid_o is seen
    task automatic wait_result(input string tag, input logic [15:0] expv);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (valid_o === 1'b1) seen = 1;
        end
        check_eq({tag, "_lat"}, n, 18);
        check_eq(tag, result(), expv);
    endtask

    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] expv);
        @(negedge clk);
        wait_ready(tag);
        drive(x);
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        drive(16'($urandom));
        wait_result(tag, expv);
        @(posedge clk);
        #1;
        check_eq({tag, "_strobe"}, valid_o, 0);
    endtask

    logic [15:0] burst_x [3];
    logic [15:0] burst_y [3];
    int          p0;

    initial begin
        tests   = 0;
        fails   = 0;
        pulses  = 0;
        rst_n   = 1'b0;
        valid_i = 1'b1;
        drive(16'h3F80);

        // reset state, with valid_i asserted during reset
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", ready_o, 1);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_res", result(), 16'h0000);
        @(negedge clk);
        rst_n   = 1'b1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_idle", ready_o, 1);

        // basic values
        run_op("one",      16'h3F80, 16'h4000);
        run_op("neg_one",  16'hBF80, 16'h3F00);
        run_op("zero",     16'h0000, 16'h3F80);
        run_op("half",     16'h3F00, 16'h3FB5);
        run_op("neg_half", 16'hBF00, 16'h3F35);
        run_op("one_half", 16'h3FC0, 16'h4035);
        run_op("quarter",  16'h3E80, 16'h3F98);
        run_op("tiny",     16'h3700, 16'h3F80);

        // specials
        run_op("p128",     16'h4300, 16'h7F80);
        run_op("n200",     16'hC348, 16'h0000);
        run_op("nan",      16'h7FC1, 16'h7FC0);
        run_op("ninf",     16'hFF80, 16'h0000);
        run_op("pinf",     16'h7F80, 16'h7F80);

        // exponent range edges
        run_op("n126",     16'hC2FC, 16'h0080);
        run_op("n127",     16'hC2FE, 16'h0000);
        run_op("p127",     16'h42FE, 16'h7F00);

        // continuous valid_i: accept again on the valid_o cycle
        burst_x[0] = 16'h3F80; burst_y[0] = 16'h4000;
        burst_x[1] = 16'h3F00; burst_y[1] = 16'h3FB5;
        burst_x[2] = 16'hC2FC; burst_y[2] = 16'h0080;
        @(negedge clk);
        p0      = pulses;
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            wait_ready($sformatf("burst%0d", i));
            drive(burst_x[i]);
            @(posedge clk);
            #1;
            drive(16'h3F80 ^ 16'(i + 1));
            wait_result($sformatf("burst%0d", i), burst_y[i]);
            check_eq($sformatf("burst%0d_rdy_on_valid", i), ready_o, 1);
        end
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("burst_pulses", pulses - p0, 3);

        // reset in the middle of iteration
        @(negedge clk);
        wait_ready("mid_rst");
        drive(16'h3F80);
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", ready_o, 1);
        check_eq("mid_rst_valid", valid_o, 0);
        check_eq("mid_rst_res", result(), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        p0    = pulses;
        repeat (25) @(posedge clk);
        #1;
        check_eq("mid_rst_no_result", pulses - p0, 0);
        check_eq("mid_rst_idle", ready_o, 1);
        run_op("after_rst", 16'hBF80, 16'h3F00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fexp2_top.md
Name: fexp2_top

Overview:
- BFloat16 base-2 antilogarithm unit: computes y = 2^x for one bfloat16 operand x and returns y as bfloat16.
- It is the inverse companion of the flog log2 datapath. Where flog goes float→log2→float, this block goes float→fixed (integer + fraction)→2^fraction→float.
- Single-issue and iterative: one bit of the fraction is consumed per cycle through a constant ROM and a multiplier.
- Latency is fixed for every input class, including specials.

Parameters:
- EXP_WIDTH, 8: exponent field width.
- MAN_WIDTH, 7: stored mantissa width.
- BIAS, 127: exponent bias.
- FRAC_W, 16: fixed-point fraction bits. This is also the iteration count.
- INT_W, 8: signed integer-part width of the internal fixed-point value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- sign  in  1  sign of x.
- exponent  in  EXP_WIDTH  biased exponent of x.
- fractional  in  MAN_WIDTH  mantissa of x.
- valid_i  in  1  input valid; accepted when ready_o=1.
- ready_o  out  1  block idle and able to accept.
- s_res_o  out  1  result sign; always 0 except for NaN passthrough, which is also 0.
- e_res_o  out  EXP_WIDTH  result exponent.
- f_res_o  out  MAN_WIDTH  result mantissa.
- valid_o  out  1  one-cycle result strobe.

Behaviour:
- Reset:
  - rst_n=0 asynchronously clears all state regardless of current state.
  - s/e/f_res_o=0, valid_o=0, ready_o=1, state=IDLE.
  - An in-flight operation is discarded; no valid_o is produced for it.
- States and transitions:
  - IDLE: ready_o=1. If valid_i=1, latch the operand and go to ALIGN.
  - ALIGN: decode the operand and build fixed-point x (rules below), then go to ITER.
  - ITER: runs exactly FRAC_W cycles, k=1..FRAC_W, then goes to PACK.
  - PACK: go to IDLE.
- ALIGN decode:
  - Unbiased E = exponent-BIAS.
  - mag = {1,fractional} shifted by (FRAC_W-MAN_WIDTH+E), giving Q(INT_W).FRAC_W. A negative shift is a right shift, truncating.
  - fixed = sign ? -mag : mag, in INT_W+FRAC_W bits two's complement.
  - I = fixed >>> FRAC_W (floor). F = fixed[FRAC_W-1:0], unsigned in [0,1).
- Special classification in ALIGN (a flag is stored; iteration still runs):
  - exponent=0 (zero or denormal, flushed): result 1.0 = 0x3F80.
  - exponent=255 with fractional≠0: NaN, result 0x7FC0.
  - +inf: result 0x7F80.
  - -inf: result 0x0000.
  - E>=INT_W-1 (|x|>=128): positive gives +inf; negative gives 0x0000.
  - E<-FRAC_W: F=0, I=0 or -1 per the fixed-point rules (no special case needed).
- ITER datapath:
  - Accumulator acc in Q1.FRAC_W starts at 1.0.
  - If F bit (FRAC_W-k) is set: acc = (acc*C_k) >> FRAC_W, truncating.
  - C_k = round-to-nearest(2^(2^-k) · 2^FRAC_W), held in a ROM generated offline. Example: C_1 = 92682.
  - acc stays in [1,2).
- PACK:
  - er = I+BIAS, signed and width-extended.
  - er<=0 gives 0x0000 (flush). er>=255 gives +inf.
  - Otherwise e_res_o=er[7:0] and f_res_o = acc[FRAC_W-1:FRAC_W-MAN_WIDTH] (truncation).
  - Specials override these results.
  - Output registers and valid_o=1 are set for one cycle.
  - Outputs hold their value until the next PACK.
- Latency and handshake:
  - valid_o rises FRAC_W+2 edges after the accepting edge (18 by default).
  - ready_o is low from the accepting edge until that same edge.
  - A new operand may be accepted in the cycle valid_o is high.
  - valid_i while busy is ignored (not queued). Operand inputs are sampled only on the accepting edge.
- Simultaneous valid_i and reset: reset wins.

Test Plan:
- Basic values, each valid_o exactly 18 cycles after accept: 0x3F80 (1.0) -> 0x4000; 0xBF80 (-1.0) -> 0x3F00; 0x0000 -> 0x3F80.
- 0x3F00 (0.5) -> 0x3FB5 (√2 truncated); 0xBF00 (-0.5) -> 0x3F35 (I=-1, F=0.5).
- Specials: 0x4300 (128) -> 0x7F80; 0xC348 (-200) -> 0x0000; 0x7FC1 -> 0x7FC0; 0xFF80 -> 0x0000; each with 18-cycle latency.
- Exponent range edges: 0xC2FC (-126) -> 0x0080; 0xC2FE (-127) -> 0x0000 (flush); 0x42FE (127) -> 0x7F00.
- Handshake: hold valid_i high continuously -> one accept per 18 cycles, back-to-back acceptance on the valid_o cycle, no dropped or duplicated results.
- Reset: pull rst_n low mid-ITER (cycle 8) -> outputs 0 and ready_o=1 immediately; no valid_o; the next operand completes normally.
